control_unit_param: RTL
=======================

CONTROL_UNIT_PARAM -- requirements
Module: control_unit_param

Interface
REQ-001 SHALL provide parameters: MEM_WAIT, default 0, range 0..15, extra wait cycles inserted before every memory-data capture; TRAP_ILLEGAL, default 1, 1 = halt on undefined opcode, 0 = treat as NOP.
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- IR  in  8  current opcode.
- CCR_Result  in  4  flags {N,Z,V,C} = bits [3:0].
- IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write_en  out  1 each  datapath strobes.
- ALU_Sel  out  3  ALU function select.
- BUS1_Sel  out  2  bus 1 source: 00 PC, 01 A, 10 B.
- BUS2_Sel  out  2  bus 2 source: 00 ALU, 01 BUS1, 10 memory.
- instr_done  out  1  one-cycle pulse in the last cycle of every instruction.
- illegal  out  1  high while halted on an undefined opcode.

Function
REQ-003 SHALL be a Moore FSM: all outputs decode from state (and wait counter) only; any output not asserted by the current step SHALL be 0, and all selects SHALL be 00.
REQ-004 Fetch SHALL run F0 (BUS2=01, MAR_Load), then F1 (PC_Inc), then F2 (BUS2=10, IR_Load), then DECODE (no strobes).
REQ-005 Wait stretching SHALL extend each step that directly precedes a memory-data capture by MEM_WAIT cycles; that step's strobes SHALL assert only in its first cycle, so PC_Inc pulses exactly once.
REQ-006 DECODE SHALL dispatch on IR: 86/88 LD A/B immediate; 87/89 LD A/B direct; 96/97 ST A/B direct; 42..49 ALU; 20..28 branch; any other value is undefined.
REQ-007 The immediate load sequence SHALL be: PC->MAR (BUS2=01, MAR_Load); PC_Inc; mem->reg (BUS2=10, A_Load or B_Load).
REQ-008 The direct load sequence SHALL be: PC->MAR; PC_Inc; mem->MAR (BUS2=10, MAR_Load); idle; mem->reg (BUS2=10, A_Load or B_Load).
REQ-009 The direct store sequence SHALL be: PC->MAR; PC_Inc; mem->MAR; then BUS1=01 (A) or 10 (B) with write_en; the store step SHALL not be wait-stretched.
REQ-010 ALU instructions SHALL execute in one step with BUS2=00, CCR_Load=1.
- 42 ADD: ALU_Sel 000, BUS1=A, A_Load.
- 43 SUB: 001, BUS1=A, A_Load.
- 44 AND: 010, BUS1=A, A_Load.
- 45 OR: 011, BUS1=A, A_Load.
- 46/47 INC A/B: 100, BUS1=A/B, A_Load/B_Load.
- 48/49 DEC A/B: 101, BUS1=A/B, A_Load/B_Load.
REQ-011 Branch condition SHALL be sampled in DECODE.
- 20: always.
- 21: N=1; 22: N=0.
- 23: Z=1; 24: Z=0.
- 25: V=1; 26: V=0.
- 27: C=1; 28: C=0.
REQ-012 A taken branch SHALL run: PC->MAR; idle; mem->PC (BUS2=10, PC_Load). A not-taken branch SHALL run one step with PC_Inc to skip the operand.
REQ-013 instr_done SHALL pulse in the final step of each instruction (store, ALU, load data step, PC_Load step, not-taken step, or DECODE for a NOP'd opcode).
REQ-014 After instr_done the next state SHALL be F0.
REQ-015 With TRAP_ILLEGAL=1, an undefined opcode SHALL enter HALT: all strobes 0, illegal=1, held until rst. With TRAP_ILLEGAL=0 it SHALL pulse instr_done in DECODE and return to F0.
REQ-016 Base latency at MEM_WAIT=0, fetch through completion: LD imm 7, LD dir 9, ST dir 8, ALU 5, branch taken 7, not taken 5 cycles. Each memory capture SHALL add MEM_WAIT cycles: fetch 1, LD imm 2, LD dir 3, ST 2, taken branch 2, ALU and not-taken 1 (fetch only).

Reset
REQ-017 With rst high at a clk edge, the FSM SHALL enter RST state regardless of the current state, including mid-instruction, wait count, or HALT; the wait counter SHALL clear.
REQ-018 In RST all outputs SHALL be 0, including illegal and instr_done; RST SHALL go to F0 on the first edge with rst low.

Verification
REQ-019 Reset, then IR=86 at F2, MEM_WAIT=0 -> MAR_Load at cycles 1 and 5, PC_Inc at 2 and 6, A_Load with BUS2=10 and instr_done at cycle 7; F0 at cycle 8.
REQ-020 IR=23 with CCR=0100 -> PC_Load with BUS2=10 three cycles after DECODE. IR=23 with CCR=0000 -> single PC_Inc with instr_done in the cycle after DECODE.
REQ-021 MEM_WAIT=2 with IR=87 -> PC_Inc high for exactly 1 cycle in each of 2 PC_Inc steps; total instruction 15 cycles; A_Load once.
REQ-022 IR=49 -> one cycle with ALU_Sel=101, BUS1=10, BUS2=00, B_Load=1, CCR_Load=1, A_Load=0.
REQ-023 IR=FF with TRAP_ILLEGAL=1 -> illegal=1 from the cycle after DECODE, no strobes for 20 cycles; rst -> illegal=0 and F0 sequence restarts.
REQ-024 rst asserted during the store step of IR=97 -> write_en=0 the next cycle, all outputs 0, F0 one cycle after rst deasserts.

Source files
------------

// File: rtl/control_unit_param.sv
// ---------------------------------------------------------------------------
// control_unit_param
//
// Moore-style sequencer for a small 8-bit accumulator CPU. It walks through
// fetch (F0..F2), DECODE and a per-instruction execute sequence, and drives
// the datapath strobes and bus selects for each step.
//
// Parameters
//   MEM_WAIT     : 0..15 extra cycles spent in every step that directly
//                  precedes a memory-data capture (strobes fire only in the
//                  first cycle of a stretched step).
//   TRAP_ILLEGAL : 1 = undefined opcode halts (illegal=1 until rst),
//                  0 = undefined opcode completes as a NOP in DECODE.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   IR                : current opcode from the instruction register
//   CCR_Result        : flags {N,Z,V,C} in bits [3:0]
//   IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write_en
//                     : one-bit datapath strobes
//   ALU_Sel           : ALU function select
//   BUS1_Sel          : bus 1 source (00 PC, 01 A, 10 B)
//   BUS2_Sel          : bus 2 source (00 ALU, 01 BUS1, 10 memory)
//   instr_done        : one-cycle pulse in the last step of each instruction
//   illegal           : high while halted on an undefined opcode
// ---------------------------------------------------------------------------
module control_unit_param #(
  parameter int MEM_WAIT     = 0,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic       write_en,
  output logic [2:0] ALU_Sel,
  output logic [1:0] BUS1_Sel,
  output logic [1:0] BUS2_Sel,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  localparam logic [1:0] B1_PC  = 2'b00;
  localparam logic [1:0] B1_A   = 2'b01;
  localparam logic [1:0] B1_B   = 2'b10;
  localparam logic [1:0] B2_ALU = 2'b00;
  localparam logic [1:0] B2_B1  = 2'b01;
  localparam logic [1:0] B2_MEM = 2'b10;

  typedef enum logic [4:0] {
    S_RST,
    S_F0, S_F1, S_F2, S_DECODE,
    S_LDI0, S_LDI1, S_LDI2,
    S_LDD0, S_LDD1, S_LDD2, S_LDD3, S_LDD4,
    S_ST0, S_ST1, S_ST2, S_ST3,
    S_ALU,
    S_BR0, S_BR1, S_BR2,
    S_BNT,
    S_HALT
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] wait_reg, wait_next;
  logic [7:0] op_reg, op_next;

  // Opcode classification of the live IR, used only while in DECODE.
  logic is_ldi, is_ldd, is_st, is_alu, is_br, is_undef, br_taken;

  always_comb begin
    is_ldi   = (IR == 8'h86) || (IR == 8'h88);
    is_ldd   = (IR == 8'h87) || (IR == 8'h89);
    is_st    = (IR == 8'h96) || (IR == 8'h97);
    is_alu   = (IR >= 8'h42) && (IR <= 8'h49);
    is_br    = (IR >= 8'h20) && (IR <= 8'h28);
    is_undef = !(is_ldi || is_ldd || is_st || is_alu || is_br);
    case (IR)
      8'h20:   br_taken = 1'b1;
      8'h21:   br_taken =  CCR_Result[3];
      8'h22:   br_taken = !CCR_Result[3];
      8'h23:   br_taken =  CCR_Result[2];
      8'h24:   br_taken = !CCR_Result[2];
      8'h25:   br_taken =  CCR_Result[1];
      8'h26:   br_taken = !CCR_Result[1];
      8'h27:   br_taken =  CCR_Result[0];
      8'h28:   br_taken = !CCR_Result[0];
      default: br_taken = 1'b0;
    endcase
  end

  // Steps that sit right before a memory-data capture get stretched by
  // MEM_WAIT cycles. The store step is deliberately not in this list.
  logic stretched;
  logic first_cycle;

  always_comb begin
    stretched   = state_reg inside {S_F1, S_LDI1, S_LDD1, S_LDD3, S_ST1, S_BR1};
    first_cycle = (wait_reg == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_RST;
      wait_reg  <= 4'd0;
      op_reg    <= 8'h00;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      op_reg    <= op_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    wait_next  = 4'd0;
    op_next    = op_reg;
    if (stretched && (wait_reg != WAIT_LAST)) begin
      wait_next = wait_reg + 4'd1;
    end else begin
      case (state_reg)
        S_RST:    state_next = S_F0;
        S_F0:     state_next = S_F1;
        S_F1:     state_next = S_F2;
        S_F2:     state_next = S_DECODE;
        S_DECODE: begin
          // The opcode is captured so the execute steps decode from our own
          // state rather than from the datapath's IR.
          op_next = IR;
          if (is_ldi)      state_next = S_LDI0;
          else if (is_ldd) state_next = S_LDD0;
          else if (is_st)  state_next = S_ST0;
          else if (is_alu) state_next = S_ALU;
          else if (is_br)  state_next = br_taken ? S_BR0 : S_BNT;
          else             state_next = TRAP_ILLEGAL ? S_HALT : S_F0;
        end
        S_LDI0:   state_next = S_LDI1;
        S_LDI1:   state_next = S_LDI2;
        S_LDI2:   state_next = S_F0;
        S_LDD0:   state_next = S_LDD1;
        S_LDD1:   state_next = S_LDD2;
        S_LDD2:   state_next = S_LDD3;
        S_LDD3:   state_next = S_LDD4;
        S_LDD4:   state_next = S_F0;
        S_ST0:    state_next = S_ST1;
        S_ST1:    state_next = S_ST2;
        S_ST2:    state_next = S_ST3;
        S_ST3:    state_next = S_F0;
        S_ALU:    state_next = S_F0;
        S_BR0:    state_next = S_BR1;
        S_BR1:    state_next = S_BR2;
        S_BR2:    state_next = S_F0;
        S_BNT:    state_next = S_F0;
        S_HALT:   state_next = S_HALT;
        default:  state_next = S_RST;
      endcase
    end
  end

  // Output decode: everything defaults to 0 / select 00.
  always_comb begin
    IR_Load    = 1'b0;
    MAR_Load   = 1'b0;
    PC_Load    = 1'b0;
    PC_Inc     = 1'b0;
    A_Load     = 1'b0;
    B_Load     = 1'b0;
    CCR_Load   = 1'b0;
    write_en   = 1'b0;
    ALU_Sel    = 3'b000;
    BUS1_Sel   = B1_PC;
    BUS2_Sel   = B2_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      S_F0, S_LDI0, S_LDD0, S_ST0, S_BR0: begin
        BUS2_Sel = B2_B1;
        MAR_Load = 1'b1;
      end
      S_F1, S_LDI1, S_LDD1, S_ST1: begin
        PC_Inc = first_cycle;
      end
      S_F2: begin
        BUS2_Sel = B2_MEM;
        IR_Load  = 1'b1;
      end
      S_DECODE: begin
        // A NOP'd undefined opcode completes right here.
        instr_done = !TRAP_ILLEGAL && is_undef;
      end
      S_LDI2: begin
        BUS2_Sel   = B2_MEM;
        A_Load     = (op_reg != 8'h88);
        B_Load     = (op_reg == 8'h88);
        instr_done = 1'b1;
      end
      S_LDD2, S_ST2: begin
        BUS2_Sel = B2_MEM;
        MAR_Load = 1'b1;
      end
      S_LDD4: begin
        BUS2_Sel   = B2_MEM;
        A_Load     = (op_reg != 8'h89);
        B_Load     = (op_reg == 8'h89);
        instr_done = 1'b1;
      end
      S_ST3: begin
        BUS1_Sel   = (op_reg == 8'h97) ? B1_B : B1_A;
        write_en   = 1'b1;
        instr_done = 1'b1;
      end
      S_ALU: begin
        BUS2_Sel   = B2_ALU;
        CCR_Load   = 1'b1;
        instr_done = 1'b1;
        BUS1_Sel   = B1_A;
        A_Load     = 1'b1;
        case (op_reg)
          8'h42:   ALU_Sel = 3'b000;
          8'h43:   ALU_Sel = 3'b001;
          8'h44:   ALU_Sel = 3'b010;
          8'h45:   ALU_Sel = 3'b011;
          8'h46:   ALU_Sel = 3'b100;
          8'h47: begin
            ALU_Sel  = 3'b100;
            BUS1_Sel = B1_B;
            A_Load   = 1'b0;
            B_Load   = 1'b1;
          end
          8'h48:   ALU_Sel = 3'b101;
          8'h49: begin
            ALU_Sel  = 3'b101;
            BUS1_Sel = B1_B;
            A_Load   = 1'b0;
            B_Load   = 1'b1;
          end
          default: ALU_Sel = 3'b000;
        endcase
      end
      S_BR2: begin
        BUS2_Sel   = B2_MEM;
        PC_Load    = 1'b1;
        instr_done = 1'b1;
      end
      S_BNT: begin
        PC_Inc     = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

endmodule
